// File: rtl/dreg_sequencer.sv
// dreg_sequencer: runs one read-load-exchange-writeback transaction
// between the shared data memory port and the two-slot dreg block.
module dreg_sequencer #(
  parameter int HALF_W = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_a_i,
  input  logic [ADDR_W-1:0]   addr_b_i,
  input  logic                exch_i,
  output logic                ready_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rden_o,
  input  logic [2*HALF_W-1:0] mem_rdata_i,
  output logic                mem_wren_o,
  output logic [2*HALF_W-1:0] mem_wdata_o,
  output logic                dreg_sel_o,
  output logic                dreg_wren_o,
  output logic                dreg_exchange_o,
  output logic [2*HALF_W-1:0] dreg_data_o,
  input  logic [2*HALF_W-1:0] dreg_data_i,
  output logic [CNT_W-1:0]    txn_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_LD_B,
    S_EXCH,
    S_WB_A,
    S_WB_B,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_a_q;
  logic [ADDR_W-1:0]   addr_b_q;
  logic                exch_q;
  logic [CNT_W-1:0]    cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      exch_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        addr_a_q <= addr_a_i;
        addr_b_q <= addr_b_i;
        exch_q   <= exch_i;
      end
      if (state_q == S_DONE && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    done_o          = 1'b0;
    mem_addr_o      = '0;
    mem_rden_o      = 1'b0;
    mem_wren_o      = 1'b0;
    dreg_sel_o      = 1'b0;
    dreg_wren_o     = 1'b0;
    dreg_exchange_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_d = S_RD_A;
      end
      S_RD_A: begin
        mem_rden_o = 1'b1;
        mem_addr_o = addr_a_q;
        state_d    = S_RD_B;
      end
      // word A arrives here while word B is being read
      S_RD_B: begin
        mem_rden_o  = 1'b1;
        mem_addr_o  = addr_b_q;
        dreg_wren_o = 1'b1;
        state_d     = S_LD_B;
      end
      S_LD_B: begin
        dreg_wren_o = 1'b1;
        dreg_sel_o  = 1'b1;
        state_d     = exch_q ? S_EXCH : S_WB_A;
      end
      S_EXCH: begin
        dreg_exchange_o = 1'b1;
        state_d         = S_WB_A;
      end
      S_WB_A: begin
        mem_wren_o = 1'b1;
        mem_addr_o = addr_a_q;
        state_d    = S_WB_B;
      end
      S_WB_B: begin
        mem_wren_o = 1'b1;
        mem_addr_o = addr_b_q;
        dreg_sel_o = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_wdata_o = dreg_data_i;
  assign dreg_data_o = mem_rdata_i;
  assign txn_cnt_o   = cnt_q;

endmodule

// File: tb/tb_dreg_sequencer.sv
// tb_dreg_sequencer: memory and dreg environment, schedule-based
// reference model checked every cycle, plus directed literal checks.
module tb_dreg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  a = '0;
  logic [9:0]  b = '0;
  logic        exch = 1'b0;
  logic        ready, done, rden, wren, dsel, dwren, dexch;
  logic [9:0]  maddr;
  logic [15:0] rdata, wdata, ddo, ddi;
  logic [15:0] cnt;

  logic        ready2, done2, rden2, wren2, dsel2, dwren2, dexch2;
  logic [9:0]  maddr2;
  logic [15:0] wdata2, ddo2;
  logic [15:0] zero16 = '0;
  logic [1:0]  cnt2;

  logic [15:0] mem [1024];
  logic [15:0] dslot [2];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dreg_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .addr_a_i(a), .addr_b_i(b), .exch_i(exch),
    .ready_o(ready), .done_o(done), .mem_addr_o(maddr),
    .mem_rden_o(rden), .mem_rdata_i(rdata), .mem_wren_o(wren),
    .mem_wdata_o(wdata), .dreg_sel_o(dsel), .dreg_wren_o(dwren),
    .dreg_exchange_o(dexch), .dreg_data_o(ddo), .dreg_data_i(ddi),
    .txn_cnt_o(cnt)
  );

  dreg_sequencer #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .addr_a_i(a), .addr_b_i(b), .exch_i(exch),
    .ready_o(ready2), .done_o(done2), .mem_addr_o(maddr2),
    .mem_rden_o(rden2), .mem_rdata_i(zero16), .mem_wren_o(wren2),
    .mem_wdata_o(wdata2), .dreg_sel_o(dsel2), .dreg_wren_o(dwren2),
    .dreg_exchange_o(dexch2), .dreg_data_o(ddo2), .dreg_data_i(zero16),
    .txn_cnt_o(cnt2)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    dslot[0] = '0;
    dslot[1] = '0;
  end

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (wren) mem[maddr] <= wdata;
    if (rden) rdata <= mem[maddr];
  end

  always @(posedge clk) begin
    if (dwren) dslot[dsel] <= ddo;
    else if (dexch) begin
      dslot[0] <= {dslot[0][15:8], dslot[1][15:8]};
      dslot[1] <= {dslot[0][7:0], dslot[1][7:0]};
    end
  end

  assign ddi = dslot[dsel];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  typedef struct packed {
    logic        ready, rden, wren, dwren, dsel, dexch, done;
    logic [9:0]  addr;
    logic        cwd;
    logic [15:0] wd;
    logic        cdd;
    logic [15:0] dd;
  } rec_t;

  function automatic rec_t mk(logic [6:0] f, logic [9:0] ad,
                              logic cwd, logic [15:0] wd,
                              logic cdd, logic [15:0] dd);
    rec_t r;
    {r.ready, r.rden, r.wren, r.dwren, r.dsel, r.dexch, r.done} = f;
    r.addr = ad;
    r.cwd  = cwd;
    r.wd   = wd;
    r.cdd  = cdd;
    r.dd   = dd;
    return r;
  endfunction

  // Model: an accepted request expands into its cycle-by-cycle schedule.
  rec_t        q[$];
  rec_t        cur;
  logic [15:0] mcnt = '0;
  logic [1:0]  mcnt2 = '0;

  always @(posedge clk, negedge clk, posedge rst) begin
    if (rst) begin
      q.delete();
      cur   = mk(7'b1000000, '0, 0, '0, 0, '0);
      mcnt  = '0;
      mcnt2 = '0;
    end else if (clk) begin
      if (cur.done) begin
        if (mcnt != 16'hffff) mcnt = mcnt + 1;
        if (mcnt2 != 2'b11) mcnt2 = mcnt2 + 1;
      end
      if (cur.ready && start) begin
        logic [15:0] wa, wb, ra, rb;
        wa = mem[a];
        wb = mem[b];
        ra = exch ? {wa[15:8], wb[15:8]} : wa;
        rb = exch ? {wa[7:0], wb[7:0]} : wb;
        q.push_back(mk(7'b0100000, a, 0, '0, 0, '0));
        q.push_back(mk(7'b0101000, b, 0, '0, 1, wa));
        q.push_back(mk(7'b0001100, '0, 0, '0, 1, wb));
        if (exch) q.push_back(mk(7'b0000010, '0, 0, '0, 0, '0));
        q.push_back(mk(7'b0010000, a, 1, ra, 0, '0));
        q.push_back(mk(7'b0010100, b, 1, rb, 0, '0));
        q.push_back(mk(7'b0000001, '0, 0, '0, 0, '0));
      end
    end else begin
      cur = (q.size() != 0) ? q.pop_front()
                            : mk(7'b1000000, '0, 0, '0, 0, '0);
      chk("strobes", {ready, rden, wren, dwren, dsel, dexch, done},
          {cur.ready, cur.rden, cur.wren, cur.dwren, cur.dsel,
           cur.dexch, cur.done});
      chk("mem_addr", maddr, cur.addr);
      if (cur.cwd) chk("mem_wdata", wdata, cur.wd);
      if (cur.cdd) chk("dreg_data", ddo, cur.dd);
      chk("wdata_pass", wdata, ddi);
      chk("ddata_pass", ddo, rdata);
      chk("txn_cnt", cnt, mcnt);
      chk("txn_cnt2", cnt2, mcnt2);
    end
  end

  task automatic poke(input logic [9:0] ad, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = ad;
    bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_txn(input logic [9:0] aa, input logic [9:0] bb,
                         input logic x, output int done_at,
                         output int exch_at, output int exch_n);
    int n;
    @(negedge clk);
    a = aa;
    b = bb;
    exch = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    done_at = -1;
    exch_at = -1;
    exch_n = 0;
    while (n <= 20) begin
      if (dexch) begin
        exch_n++;
        exch_at = n;
      end
      if (done) begin
        done_at = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (done_at < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", ready, 1);
  endtask

  initial begin
    int d_at, e_at, e_n, nd, c0;
    int dcyc[$];
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_strobes", {rden, wren, dwren, dexch, done}, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_sel", dsel, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    poke(10'h010, 16'h1122);
    poke(10'h020, 16'h3344);
    run_txn(10'h010, 10'h020, 1'b0, d_at, e_at, e_n);
    chk("noexch_done_cycle", d_at, 6);
    chk("noexch_no_strobe", e_n, 0);
    chk("noexch_mem_a", mem[10'h010], 16'h1122);
    chk("noexch_mem_b", mem[10'h020], 16'h3344);

    run_txn(10'h010, 10'h020, 1'b1, d_at, e_at, e_n);
    chk("exch_done_cycle", d_at, 7);
    chk("exch_strobe_cycle", e_at, 4);
    chk("exch_strobe_count", e_n, 1);
    chk("exch_mem_a", mem[10'h010], 16'h1133);
    chk("exch_mem_b", mem[10'h020], 16'h2244);

    poke(10'h005, 16'hABCD);
    c0 = cnt;
    run_txn(10'h005, 10'h005, 1'b1, d_at, e_at, e_n);
    chk("alias_mem", mem[10'h005], 16'hCDCD);
    chk("alias_cnt", cnt, c0 + 1);

    poke(10'h100, 16'h0102);
    poke(10'h101, 16'h0304);
    @(negedge clk);
    a = 10'h100;
    b = 10'h101;
    exch = 1'b1;
    start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) start = 1'b0;
      if (done) begin
        nd++;
        dcyc.push_back(i);
      end
    end
    chk("held_start_txns", nd, 3);
    if (dcyc.size() >= 2) begin
      chk("held_done1", dcyc[0], 7);
      chk("held_done2", dcyc[1], 15);
    end

    poke(10'h030, 16'h5566);
    poke(10'h031, 16'h7788);
    @(negedge clk);
    a = 10'h030;
    b = 10'h031;
    exch = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("wba_wren", wren, 1);
    chk("wba_addr", maddr, 10'h030);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_wren", wren, 0);
    chk("midrst_addr", maddr, 0);
    chk("midrst_cnt", cnt, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_b", mem[10'h031], 16'h7788);
    chk("midrst_mem_a", mem[10'h030], 16'h5566);
    run_txn(10'h030, 10'h031, 1'b1, d_at, e_at, e_n);
    chk("after_rst_done", d_at, 7);
    chk("after_rst_mem_a", mem[10'h030], 16'h5577);
    chk("after_rst_mem_b", mem[10'h031], 16'h6688);
    chk("after_rst_cnt", cnt, 1);

    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_txn(10'h040, 10'h041, 1'b0, d_at, e_at, e_n);
    end
    chk("sat_cnt2", cnt2, 3);
    chk("sat_cnt16", cnt, 5);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
